alu_serial_nbit: RTL and testbench
==================================

# alu_serial_nbit

Parametrised bit-serial ALU: a WIDTH-bit operation is computed one bit per clock, LSB first, through a single 1-bit ALU slice (A, B, Cin, S → F, Cout). Sits beside the combinational 1-bit slice as its multi-bit, sequential successor. Adds subtraction, a start/done handshake and status flags (carry, overflow, zero). Intended for area-constrained datapaths where latency of WIDTH cycles is acceptable.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..64.

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only when busy=0
- A  in  WIDTH  operand A, captured on accepted start
- B  in  WIDTH  operand B, captured on accepted start
- Cin  in  1  carry in for ADD, captured on accepted start
- S  in  3  operation select, captured on accepted start
- F  out  WIDTH  result of last completed operation
- Cout  out  1  carry out of last completed operation
- V  out  1  signed overflow of last completed operation
- Z  out  1  1 when F == 0
- busy  out  1  operation in progress
- done  out  1  single-cycle completion pulse

## Operation
- S encoding:
  - 000 AND
  - 001 OR
  - 010 XOR
  - 011 ADD (A+B+Cin)
  - 100 SUB (A+~B+1; Cin ignored)
  - 101–111 reserved: F=0, Cout=0, V=0, Z=1
- Internal state: operand shift registers A_sh and B_sh, result shift register R_sh, carry register c, op register, bit counter (ceil(log2 WIDTH) bits).
- States:
  - IDLE → RUN on start=1.
  - RUN → IDLE after bit WIDTH-1 is processed.
- Accepted start (IDLE, start=1):
  - load A_sh=A, B_sh=B.
  - load c=Cin for ADD, c=1 for SUB, c=0 otherwise.
  - counter=0, busy<=1.
- RUN, each edge:
  - slice inputs a=A_sh[0], b=B_sh[0] (inverted for SUB), carry c.
  - logic ops: bitwise result; c unchanged and unused.
  - ADD/SUB: full-adder sum; c<=carry out of the slice.
  - result bit shifts into R_sh MSB; A_sh and B_sh shift right; counter increments.
- On the edge processing bit WIDTH-1:
  - F<=final result; Cout<=final carry (ADD/SUB) else 0.
  - V<=carry-into-MSB XOR carry-out (ADD/SUB) else 0.
  - Z<=(result==0); busy<=0; done<=1.
- SUB Cout convention: 1 = no borrow (A ≥ B unsigned).
- F, Cout, V and Z hold the previous result for the whole of RUN and change only on the completion edge.
- start while busy=1 is ignored, with no queuing; in-flight operands are unaffected by input changes.

## Timing
- Reset values: F=0, Cout=0, V=0, Z=1, busy=0, done=0; state IDLE, counter 0.
- Start accepted on edge k:
  - busy=1 from edge k until edge k+WIDTH.
  - F, flags and done=1 valid after edge k+WIDTH.
  - done drops after edge k+WIDTH+1 unless a new operation completes.
- Latency: exactly WIDTH cycles from the accepting edge to done.
- Throughput: one operation per WIDTH cycles. start=1 during the done cycle (busy=0) is accepted; back-to-back operations leave no idle cycle.
- rst=1 on any edge overrides everything, including mid-RUN and a coincident start: the operation is discarded, all outputs return to reset values, and no done is emitted for the aborted operation.
- done and busy are never high in the same cycle.

## Test plan
- WIDTH=8, ADD, A=FF, B=01, Cin=0 → after 8 cycles: F=00, Cout=1, V=0, Z=1, one-cycle done.
- ADD, A=7F, B=01, Cin=0 → F=80, Cout=0, V=1, Z=0. ADD, A=10, B=20, Cin=1 → F=31, Cout=0, V=0.
- SUB, A=05, B=07 → F=FE, Cout=0, V=0. SUB, A=80, B=01 → F=7F, Cout=1, V=1.
- Logic and reserved ops, A=A5, B=FF:
  - XOR → F=5A, Cout=0, V=0.
  - AND → F=A5.
  - OR, A=00, B=00 → F=00, Z=1.
  - S=110 → F=00, Z=1.
- Protocol:
  - start pulsed again mid-RUN with different operands → ignored; original result returned at the original done cycle.
  - start held during the done cycle → second op completes exactly 8 cycles later.
  - F stays stable throughout RUN.
- rst asserted 3 cycles into RUN → next cycle busy=0, F=0, Z=1, no done pulse. A subsequent start completes normally; repeat at WIDTH=16 and WIDTH=2 for counter wrap.

Source files
------------

// File: rtl/alu_serial_nbit.sv
`default_nettype none
// ============================================================================
// Module   : alu_serial_nbit
// Function : Bit-serial WIDTH-bit ALU (AND/OR/XOR/ADD/SUB), one bit per clock,
//            LSB first, with start/done handshake and carry/overflow/zero flags.
// Revision : 1.0
// ============================================================================
module alu_serial_nbit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic [2:0]       S,
    output logic [WIDTH-1:0] F,
    output logic             Cout,
    output logic             V,
    output logic             Z,
    output logic             busy,
    output logic             done
);

    localparam int              CW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]   C_LAST    = CW'(WIDTH - 1);
    localparam logic [2:0]      C_OP_AND  = 3'b000;
    localparam logic [2:0]      C_OP_OR   = 3'b001;
    localparam logic [2:0]      C_OP_XOR  = 3'b010;
    localparam logic [2:0]      C_OP_ADD  = 3'b011;
    localparam logic [2:0]      C_OP_SUB  = 3'b100;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_ash;
    logic [WIDTH-1:0]   r_bsh;
    logic [WIDTH-1:0]   r_rsh;
    logic               r_c;
    logic [2:0]         r_op;
    logic [CW-1:0]      r_cnt;

    logic               w_accept;
    logic               w_run;
    logic               w_last;
    logic               w_arith;
    logic               w_a;
    logic               w_b;
    logic               w_sum;
    logic               w_cy;
    logic               w_bit;
    logic [WIDTH-1:0]   w_res;

    assign w_accept = (r_state == ST_IDLE) && start;
    assign w_run    = (r_state == ST_RUN);
    assign w_last   = w_run && (r_cnt == C_LAST);
    assign busy     = w_run;

    // Single 1-bit slice; SUB is A + ~B with the carry preloaded to 1.
    assign w_arith  = (r_op == C_OP_ADD) || (r_op == C_OP_SUB);
    assign w_a      = r_ash[0];
    assign w_b      = r_bsh[0] ^ (r_op == C_OP_SUB);
    assign w_sum    = w_a ^ w_b ^ r_c;
    assign w_cy     = (w_a & w_b) | (r_c & (w_a ^ w_b));

    always_comb begin
        w_bit = 1'b0;
        case (r_op)
            C_OP_AND: w_bit = w_a & w_b;
            C_OP_OR:  w_bit = w_a | w_b;
            C_OP_XOR: w_bit = w_a ^ w_b;
            C_OP_ADD: w_bit = w_sum;
            C_OP_SUB: w_bit = w_sum;
            default:  w_bit = 1'b0;
        endcase
    end

    assign w_res = {w_bit, r_rsh[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start)  w_state_nxt = ST_RUN;
            ST_RUN:  if (w_last) w_state_nxt = ST_IDLE;
            default:             w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ash <= '0;
            r_bsh <= '0;
            r_rsh <= '0;
            r_c   <= 1'b0;
            r_op  <= 3'b000;
            r_cnt <= '0;
            F     <= '0;
            Cout  <= 1'b0;
            V     <= 1'b0;
            Z     <= 1'b1;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (w_accept) begin
                r_ash <= A;
                r_bsh <= B;
                r_op  <= S;
                r_c   <= (S == C_OP_ADD) ? Cin : (S == C_OP_SUB);
                r_cnt <= '0;
            end else if (w_run) begin
                r_ash <= r_ash >> 1;
                r_bsh <= r_bsh >> 1;
                r_rsh <= w_res;
                if (w_arith) begin
                    r_c <= w_cy;
                end
                r_cnt <= w_last ? '0 : r_cnt + CW'(1);
                // r_c here is the carry into the MSB, so V is its XOR with carry-out.
                if (w_last) begin
                    F    <= w_res;
                    Cout <= w_arith & w_cy;
                    V    <= w_arith & (r_c ^ w_cy);
                    Z    <= (w_res == '0);
                    done <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_serial_nbit.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_serial_nbit
// Function : Self-checking bench for alu_serial_nbit at WIDTH = 8, 16 and 2.
// Revision : 1.0
// ============================================================================
module tb_alu_serial_nbit;

    logic                clk = 1'b0;
    logic [2:0]          rst_v, start_v, cin_v;
    logic [2:0]          busy_v, done_v, cout_v, v_v, z_v;
    logic [2:0][63:0]    a_in, b_in;
    logic [2:0][2:0]     s_in;
    logic [7:0]          f8;
    logic [15:0]         f16;
    logic [1:0]          f2;

    logic [2:0][63:0]    last_f, exp_f;
    logic [2:0][2:0]     last_st, exp_st;
    int                  total = 0;
    int                  bad   = 0;

    always #5 clk = ~clk;

    alu_serial_nbit #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .A(a_in[0][7:0]), .B(b_in[0][7:0]),
        .Cin(cin_v[0]), .S(s_in[0]), .F(f8), .Cout(cout_v[0]), .V(v_v[0]), .Z(z_v[0]),
        .busy(busy_v[0]), .done(done_v[0])
    );

    alu_serial_nbit #(.WIDTH(16)) u_w16 (
        .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .A(a_in[1][15:0]), .B(b_in[1][15:0]),
        .Cin(cin_v[1]), .S(s_in[1]), .F(f16), .Cout(cout_v[1]), .V(v_v[1]), .Z(z_v[1]),
        .busy(busy_v[1]), .done(done_v[1])
    );

    alu_serial_nbit #(.WIDTH(2)) u_w2 (
        .clk(clk), .rst(rst_v[2]), .start(start_v[2]), .A(a_in[2][1:0]), .B(b_in[2][1:0]),
        .Cin(cin_v[2]), .S(s_in[2]), .F(f2), .Cout(cout_v[2]), .V(v_v[2]), .Z(z_v[2]),
        .busy(busy_v[2]), .done(done_v[2])
    );

    function automatic int wid(int d);
        return (d == 0) ? 8 : (d == 1) ? 16 : 2;
    endfunction

    function automatic logic [63:0] f_of(int d);
        return (d == 0) ? 64'(f8) : (d == 1) ? 64'(f16) : 64'(f2);
    endfunction

    // Reference: plain W-bit arithmetic; returns {Cout, V, Z, F}.
    function automatic logic [66:0] model(int w, logic [63:0] ai, logic [63:0] bi,
                                          logic cin, logic [2:0] s);
        logic [63:0] mask, a, b, f;
        logic [64:0] sum;
        logic        co, ov;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        a = ai & mask;
        b = bi & mask;
        f = '0; co = 1'b0; ov = 1'b0; sum = '0;
        case (s)
            3'd0: f = a & b;
            3'd1: f = a | b;
            3'd2: f = a ^ b;
            3'd3: begin
                sum = {1'b0, a} + {1'b0, b} + 65'(cin);
                f   = sum[63:0] & mask;
                co  = sum[w];
                ov  = (a[w-1] == b[w-1]) && (f[w-1] != a[w-1]);
            end
            3'd4: begin
                sum = {1'b0, a} + {1'b0, (~b & mask)} + 65'd1;
                f   = sum[63:0] & mask;
                co  = sum[w];
                ov  = (a[w-1] != b[w-1]) && (f[w-1] != a[w-1]);
            end
            default: f = '0;
        endcase
        return {co, ov, (f == 64'd0), f};
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] rnd64();
        return {32'($urandom), 32'($urandom)};
    endfunction

    // Drive a request now; it is accepted on the next edge, after which the inputs are scrambled.
    task automatic start_op(int d, logic [63:0] a, logic [63:0] b, logic cin, logic [2:0] s);
        logic [66:0] m;
        a_in[d] = a; b_in[d] = b; cin_v[d] = cin; s_in[d] = s; start_v[d] = 1'b1;
        m = model(wid(d), a, b, cin, s);
        exp_f[d]  = m[63:0];
        exp_st[d] = m[66:64];
        tick();
        start_v[d] = 1'b0;
        a_in[d] = rnd64(); b_in[d] = rnd64();
        cin_v[d] = 1'($urandom); s_in[d] = 3'($urandom);
    endtask

    task automatic finish_op(int d, int pulse_at);
        for (int j = 0; j < wid(d); j++) begin
            chk($sformatf("run_ctl d%0d c%0d", d, j),
                64'({busy_v[d], done_v[d], cout_v[d], v_v[d], z_v[d]}),
                64'({2'b10, last_st[d]}));
            chk($sformatf("run_F d%0d c%0d", d, j), f_of(d), last_f[d]);
            if (j == pulse_at) begin
                start_v[d] = 1'b1;
                a_in[d] = rnd64(); b_in[d] = rnd64(); s_in[d] = 3'($urandom_range(0, 4));
            end else begin
                start_v[d] = 1'b0;
            end
            tick();
        end
        start_v[d] = 1'b0;
        chk($sformatf("done_ctl d%0d", d), 64'({busy_v[d], done_v[d]}), 64'(2'b01));
        chk($sformatf("res_F d%0d", d), f_of(d), exp_f[d]);
        chk($sformatf("res_CVZ d%0d", d), 64'({cout_v[d], v_v[d], z_v[d]}), 64'(exp_st[d]));
        last_f[d]  = exp_f[d];
        last_st[d] = exp_st[d];
    endtask

    task automatic idle_chk(int d);
        tick();
        chk($sformatf("idle_ctl d%0d", d), 64'({busy_v[d], done_v[d]}), 64'(2'b00));
    endtask

    task automatic do_op(int d, logic [63:0] a, logic [63:0] b, logic cin, logic [2:0] s);
        start_op(d, a, b, cin, s);
        finish_op(d, -1);
        idle_chk(d);
    endtask

    task automatic chk_reset_state(int d, string tag);
        chk({tag, "_ctl"}, 64'({busy_v[d], done_v[d], cout_v[d], v_v[d], z_v[d]}), 64'(5'b00001));
        chk({tag, "_F"}, f_of(d), 64'd0);
        last_f[d]  = '0;
        last_st[d] = 3'b001;
    endtask

    // Reset three edges into RUN, with a coincident start; no done may follow.
    task automatic abort_op(int d);
        start_op(d, rnd64(), rnd64(), 1'b0, 3'd3);
        tick();
        tick();
        rst_v[d] = 1'b1;
        start_v[d] = 1'b1;
        tick();
        rst_v[d] = 1'b0;
        start_v[d] = 1'b0;
        chk_reset_state(d, $sformatf("abort d%0d", d));
        for (int j = 0; j < wid(d) + 2; j++) begin
            chk($sformatf("abort_quiet d%0d c%0d", d, j),
                64'({busy_v[d], done_v[d]}), 64'(2'b00));
            tick();
        end
    endtask

    initial begin
        rst_v = 3'b111; start_v = '0; cin_v = '0; a_in = '0; b_in = '0; s_in = '0;
        tick();
        tick();
        rst_v = 3'b000;
        for (int d = 0; d < 3; d++) chk_reset_state(d, $sformatf("reset d%0d", d));

        do_op(0, 64'hFF, 64'h01, 1'b0, 3'd3);
        do_op(0, 64'h7F, 64'h01, 1'b0, 3'd3);
        do_op(0, 64'h10, 64'h20, 1'b1, 3'd3);
        do_op(0, 64'h05, 64'h07, 1'b1, 3'd4);
        do_op(0, 64'h80, 64'h01, 1'b0, 3'd4);
        do_op(0, 64'hA5, 64'hFF, 1'b0, 3'd2);
        do_op(0, 64'hA5, 64'hFF, 1'b0, 3'd0);
        do_op(0, 64'h00, 64'h00, 1'b0, 3'd1);
        do_op(0, 64'hA5, 64'hFF, 1'b0, 3'd6);

        // A second start mid-RUN must be ignored.
        start_op(0, 64'h3C, 64'h0F, 1'b0, 3'd3);
        finish_op(0, 3);
        idle_chk(0);

        // Start held through the done cycle: back-to-back, no idle gap.
        start_op(0, 64'h12, 64'h34, 1'b0, 3'd3);
        finish_op(0, -1);
        start_op(0, 64'h40, 64'h41, 1'b0, 3'd4);
        finish_op(0, -1);
        idle_chk(0);

        for (int i = 0; i < 16; i++) begin
            start_op(0, rnd64(), rnd64(), 1'($urandom), 3'($urandom_range(0, 7)));
            finish_op(0, (i % 3 == 0) ? 2 : -1);
            if (i % 2 == 1) idle_chk(0);
        end

        for (int d = 0; d < 3; d++) begin
            abort_op(d);
            do_op(d, rnd64(), rnd64(), 1'($urandom), 3'd3);
            for (int i = 0; i < 8; i++) begin
                start_op(d, rnd64(), rnd64(), 1'($urandom), 3'($urandom_range(0, 7)));
                finish_op(d, -1);
            end
            idle_chk(d);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
